// File: rtl/wb_grf.sv
// Write-back stage and 32-entry general register file.
// Selects the W-stage write-back datum, commits it to the GPR file, exposes two
// combinational read ports with same-cycle write bypass, and records a commit
// count plus the most recent commit for trace comparison.
module wb_grf #(
  parameter int DW     = 32,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RFA3W,
  input  logic             RegWrite_W,
  input  logic [1:0]       WDsel_W,
  input  logic [DW-1:0]    AO_W,
  input  logic [DW-1:0]    DR_W,
  input  logic [DW-1:0]    PC8_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [DW-1:0]    RD1,
  output logic [DW-1:0]    RD2,
  output logic [DW-1:0]    WD_W,
  output logic             wr_fire,
  output logic [CNT_W-1:0] commit_cnt = '0,
  output logic [4:0]       last_addr  = '0,
  output logic [DW-1:0]    last_data  = '0
);

  // Register storage; entry 0 is never written, so it stays zero.
  logic [DW-1:0] gpr [32] = '{default: '0};

  // Write-back source select; 00 means the instruction produces no result.
  function automatic logic [DW-1:0] sel_wd(input logic [1:0] sel,
                                           input logic [DW-1:0] ao,
                                           input logic [DW-1:0] dr,
                                           input logic [DW-1:0] pc8);
    case (sel)
      2'b01:   return ao;
      2'b10:   return dr;
      2'b11:   return pc8;
      default: return '0;
    endcase
  endfunction

  // Read port: $0 is hard zero, the register being committed this cycle is
  // forwarded so the D stage never sees a stale value.
  function automatic logic [DW-1:0] rd_port(input logic [4:0]    a,
                                            input logic          fire,
                                            input logic [4:0]    wa,
                                            input logic [DW-1:0] wd,
                                            input logic [DW-1:0] stored);
    if (a == 5'd0)
      return '0;
    else if (BYPASS && fire && (a == wa))
      return wd;
    else
      return stored;
  endfunction

  // Write-back data and commit qualification.
  always_comb begin
    WD_W    = sel_wd(WDsel_W, AO_W, DR_W, PC8_W);
    wr_fire = RegWrite_W & (WDsel_W != 2'b00) & (RFA3W != 5'd0);
  end

  // Both read ports, including simultaneous bypass when A1 == A2 == RFA3W.
  always_comb begin
    RD1 = rd_port(A1, wr_fire, RFA3W, WD_W, gpr[A1]);
    RD2 = rd_port(A2, wr_fire, RFA3W, WD_W, gpr[A2]);
  end

  // Commit: reset clears everything and overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      commit_cnt <= '0;
      last_addr  <= '0;
      last_data  <= '0;
    end else if (wr_fire) begin
      gpr[RFA3W] <= WD_W;
      commit_cnt <= commit_cnt + 1'b1;
      last_addr  <= RFA3W;
      last_data  <= WD_W;
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: a reference GPR model checks the combinational ports each
// cycle, and a commit scoreboard checks the registered trace outputs.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  RFA3W = '0;
  logic        RegWrite_W = 1'b0;
  logic [1:0]  WDsel_W = '0;
  logic [31:0] AO_W = '0, DR_W = '0, PC8_W = '0;
  logic [4:0]  A1 = '0, A2 = '0;
  logic [31:0] RD1, RD2, WD_W, commit_cnt, last_data;
  logic        wr_fire;
  logic [4:0]  last_addr;
  logic [31:0] RD1_s, RD2_s, WD_W_s, last_data_s;
  logic        wr_fire_s;
  logic [4:0]  last_addr_s;
  logic [3:0]  cnt4;

  wb_grf #(.DW(32), .BYPASS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .RFA3W(RFA3W), .RegWrite_W(RegWrite_W),
    .WDsel_W(WDsel_W), .AO_W(AO_W), .DR_W(DR_W), .PC8_W(PC8_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .wr_fire(wr_fire),
    .commit_cnt(commit_cnt), .last_addr(last_addr), .last_data(last_data)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  wb_grf #(.DW(32), .BYPASS(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .RFA3W(RFA3W), .RegWrite_W(RegWrite_W),
    .WDsel_W(WDsel_W), .AO_W(AO_W), .DR_W(DR_W), .PC8_W(PC8_W),
    .A1(A1), .A2(A2), .RD1(RD1_s), .RD2(RD2_s), .WD_W(WD_W_s), .wr_fire(wr_fire_s),
    .commit_cnt(cnt4), .last_addr(last_addr_s), .last_data(last_data_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] c;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] ref_gpr [32];
  logic [31:0] ref_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_gpr[i] = '0;
    ref_cnt = '0;
  endtask

  // One cycle of stimulus: check combinational ports mid-cycle, then the
  // registered trace outputs just after the edge.
  task automatic step(input logic rw, input logic [1:0] sel, input logic [4:0] a3,
                      input logic [31:0] ao, input logic [31:0] dr, input logic [31:0] pc8,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] wd, e1, e2;
    logic        fire;
    logic [3:0]  c4;
    ent_t        e;
    @(negedge clk);
    RegWrite_W = rw; WDsel_W = sel; RFA3W = a3;
    AO_W = ao; DR_W = dr; PC8_W = pc8; A1 = a1; A2 = a2;
    case (sel)
      2'b01:   wd = ao;
      2'b10:   wd = dr;
      2'b11:   wd = pc8;
      default: wd = 32'h0;
    endcase
    fire = rw && (sel != 2'b00) && (a3 != 5'd0);
    e1 = (a1 == 0) ? 32'h0 : (fire && a1 == a3) ? wd : ref_gpr[a1];
    e2 = (a2 == 0) ? 32'h0 : (fire && a2 == a3) ? wd : ref_gpr[a2];
    #1;
    chk("wd_w", WD_W, wd);
    chk("wr_fire", wr_fire, fire);
    chk("rd1", RD1, e1);
    chk("rd2", RD2, e2);
    if (fire) begin
      ref_cnt = ref_cnt + 1;
      ref_gpr[a3] = wd;
      sb.push_back('{a: a3, d: wd, c: ref_cnt});
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      c4 = e.c[3:0];
      chk("last_addr", last_addr, e.a);
      chk("last_data", last_data, e.d);
      chk("commit_cnt", commit_cnt, e.c);
      chk("commit_cnt4", cnt4, c4);
    end else begin
      c4 = ref_cnt[3:0];
      chk("cnt_hold", commit_cnt, ref_cnt);
      chk("cnt4_hold", cnt4, c4);
    end
  endtask

  // Reset for one edge, optionally with a write presented at the same time.
  task automatic do_reset(input logic wr, input logic [4:0] a3, input logic [31:0] ao);
    @(negedge clk);
    reset = 1'b1; RegWrite_W = wr; WDsel_W = wr ? 2'b01 : 2'b00; RFA3W = a3; AO_W = ao;
    #1;
    chk("rst_fire_comb", wr_fire, wr && (a3 != 0));
    @(posedge clk);
    #1;
    reset = 1'b0; RegWrite_W = 1'b0; WDsel_W = 2'b00;
    clear_model();
    chk("rst_cnt", commit_cnt, 32'h0);
    chk("rst_cnt4", cnt4, 4'h0);
    chk("rst_last_addr", last_addr, 5'h0);
    chk("rst_last_data", last_data, 32'h0);
  endtask

  initial begin
    clear_model();
    #1;
    chk("pwr_cnt", commit_cnt, 32'h0);
    chk("pwr_last_data", last_data, 32'h0);

    // Basic reset, then reads of cleared registers.
    do_reset(1'b0, 5'd0, 32'h0);
    step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);

    // ALU write with same-cycle bypass, then hold.
    step(1'b1, 2'b01, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8);

    // DM and link writes.
    step(1'b1, 2'b10, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd8);
    step(1'b1, 2'b11, 5'd31, 32'h0, 32'h0, 32'h0000_3008, 5'd31, 5'd9);
    step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd31);

    // Writes to $0 and WDsel=00 writes are dropped and not counted.
    step(1'b1, 2'b01, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    step(1'b1, 2'b00, 5'd4, 32'hAAAA_5555, 32'h0, 32'h0, 5'd4, 5'd0);
    step(1'b0, 2'b01, 5'd4, 32'hAAAA_5555, 32'h0, 32'h0, 5'd4, 5'd4);

    // Both read ports bypassing the same register.
    step(1'b1, 2'b01, 5'd12, 32'hCAFE_0001, 32'h0, 32'h0, 5'd12, 5'd12);

    // Reset wins over a concurrent write; first later commit counts as 1.
    do_reset(1'b1, 5'd3, 32'h7);
    step(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd8);
    step(1'b1, 2'b01, 5'd3, 32'h7, 32'h0, 32'h0, 5'd3, 5'd0);

    // Counter wrap on the 4-bit instance: 17 further commits.
    for (int i = 0; i < 17; i++)
      step(1'b1, 2'b01, 5'(1 + (i % 31)), 32'h100 + i, 32'h0, 32'h0, 5'(i % 32), 5'd1);

    // Randomised traffic.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           $urandom, $urandom, $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
